// File: rtl/riscky_pkg.sv
// Shared definitions for the riscky register file and its busy scoreboard.
package riscky_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int NREGS_DEFAULT = 32;
   localparam int ZERO_REG = 0;

   typedef logic [$clog2(NREGS_DEFAULT)-1:0] reg_addr_t;

endpackage : riscky_pkg

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for RAW hazard detection, with an incrementally kept
// count of busy registers. Register 0 can never be busy.
module reg_scoreboard
   import riscky_pkg::*;
#(
   parameter int NREGS = NREGS_DEFAULT,
   parameter bit BYPASS = 1'b1,
   localparam int AW = $clog2(NREGS),
   localparam int CW = $clog2(NREGS + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] src_one,
   input  logic [AW-1:0] src_two,
   input  logic          write_enable,
   input  logic [AW-1:0] dest,
   input  logic          reserve_en,
   input  logic [AW-1:0] reserve_addr,
   input  logic          flush,
   output logic          src_one_busy,
   output logic          src_two_busy,
   output logic [CW-1:0] busy_count
);

   logic [NREGS-1:0] busy_q, busy_d;
   logic [CW-1:0]    count_q, count_d;
   logic             set_hit, clr_hit;

   assign set_hit = reserve_en && (reserve_addr != AW'(ZERO_REG));
   // A reservation of the register being written names a new producer, so it keeps the bit.
   assign clr_hit = write_enable && (dest != AW'(ZERO_REG))
                    && !(set_hit && (reserve_addr == dest));

   always_comb begin
      busy_d  = busy_q;
      count_d = count_q;
      if (flush) begin
         busy_d  = '0;
         count_d = '0;
      end else begin
         if (clr_hit) begin
            busy_d[dest] = 1'b0;
            if (busy_q[dest]) count_d = count_d - CW'(1);
         end
         if (set_hit) begin
            busy_d[reserve_addr] = 1'b1;
            if (!busy_q[reserve_addr]) count_d = count_d + CW'(1);
         end
      end
      busy_d[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q  <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
      end
   end

   assign src_one_busy = busy_q[src_one] && !(BYPASS && write_enable && (dest == src_one));
   assign src_two_busy = busy_q[src_two] && !(BYPASS && write_enable && (dest == src_two));
   assign busy_count   = count_q;

endmodule : reg_scoreboard

// File: rtl/reg_file_sb.sv
// Two-read / one-write register file with hardwired zero register, optional
// writeback-to-read forwarding and a busy scoreboard for issue-stage stalls.
module reg_file_sb
   import riscky_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int NREGS = NREGS_DEFAULT,
   parameter bit BYPASS = 1'b1,
   localparam int AW = $clog2(NREGS),
   localparam int CW = $clog2(NREGS + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   src_one,
   input  logic [AW-1:0]   src_two,
   output logic [XLEN-1:0] out_one,
   output logic [XLEN-1:0] out_two,
   output logic            src_one_busy,
   output logic            src_two_busy,
   input  logic [AW-1:0]   dest,
   input  logic            write_enable,
   input  logic [XLEN-1:0] data_in,
   input  logic            reserve_en,
   input  logic [AW-1:0]   reserve_addr,
   input  logic            flush,
   output logic [CW-1:0]   busy_count
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic            fwd_one, fwd_two;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (write_enable && (dest != AW'(ZERO_REG))) begin
         regs_q[dest] <= data_in;
      end
   end

   assign fwd_one = BYPASS && write_enable && (dest == src_one);
   assign fwd_two = BYPASS && write_enable && (dest == src_two);

   // The zero check comes first so a forwarded write to register 0 never leaks out.
   always_comb begin
      out_one = '0;
      out_two = '0;
      if (src_one != AW'(ZERO_REG)) out_one = fwd_one ? data_in : regs_q[src_one];
      if (src_two != AW'(ZERO_REG)) out_two = fwd_two ? data_in : regs_q[src_two];
   end

   reg_scoreboard #(
      .NREGS  (NREGS),
      .BYPASS (BYPASS)
   ) u_scoreboard (
      .clk          (clk),
      .reset        (reset),
      .src_one      (src_one),
      .src_two      (src_two),
      .write_enable (write_enable),
      .dest         (dest),
      .reserve_en   (reserve_en),
      .reserve_addr (reserve_addr),
      .flush        (flush),
      .src_one_busy (src_one_busy),
      .src_two_busy (src_two_busy),
      .busy_count   (busy_count)
   );

endmodule : reg_file_sb
